// File: rtl/mac_pkg.sv
// Shared FSM state type and array instruction encodings for the MAC array controller.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GAP   = 3'd2,
        EXEC  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mac_ctrl_addr_gen.sv
// Sequential SRAM address source: loads a base and length, then steps one address per issued read.
module mac_ctrl_addr_gen #(
    parameter int unsigned ADDR_BW = 11,
    parameter int unsigned CNT_BW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [ADDR_BW-1:0] base_i,
    input  logic [CNT_BW-1:0]  len_i,
    input  logic               step_i,
    output logic [ADDR_BW-1:0] addr_c_o,
    output logic               all_issued_c_o
);

    logic [ADDR_BW-1:0] addr_q, addr_d;
    logic [CNT_BW-1:0]  cnt_q, cnt_d;
    logic [CNT_BW-1:0]  len_q;
    logic [CNT_BW-1:0]  cnt_cur;
    logic [CNT_BW-1:0]  len_cur;

    // A load takes effect in the same cycle so the first read can issue alongside it.
    assign cnt_cur        = load_i ? '0 : cnt_q;
    assign len_cur        = load_i ? len_i : len_q;
    assign addr_c_o       = load_i ? base_i : addr_q;
    assign all_issued_c_o = (cnt_cur == len_cur);

    always_comb begin
        addr_d = addr_c_o;
        cnt_d  = cnt_cur;
        if (step_i) begin
            addr_d = addr_c_o + ADDR_BW'(1);
            cnt_d  = cnt_cur + CNT_BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            len_q  <= len_cur;
        end
    end

endmodule

// File: rtl/mac_ctrl.sv
// MAC array controller: streams COL kernel words, then cfg_len activation vectors,
// and waits for the last column to report every result before signalling done.
module mac_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned ROW     = 8,
    parameter int unsigned COL     = 8,
    parameter int unsigned LEN_BW  = 8,
    parameter int unsigned ADDR_BW = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_BW-1:0]  cfg_len,
    input  logic [ADDR_BW-1:0] cfg_w_base,
    input  logic [ADDR_BW-1:0] cfg_x_base,
    output logic               mem_ren,
    output logic [ADDR_BW-1:0] mem_addr,
    output logic [1:0]         inst_w,
    input  logic [COL-1:0]     valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned CNT_BW      = max_u(LEN_BW, $clog2(COL + 1));
    localparam int unsigned DRAIN_LIMIT = ROW + COL + 4;
    localparam int unsigned DRAIN_BW    = $clog2(DRAIN_LIMIT + 1);

    state_t              state_q, state_d;
    logic                mem_ren_q, mem_ren_d;
    logic [ADDR_BW-1:0]  mem_addr_q, mem_addr_d;
    logic [1:0]          inst_w_q, inst_w_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [LEN_BW-1:0]   len_q, len_d;
    logic [LEN_BW-1:0]   vcnt_q, vcnt_d;
    logic [DRAIN_BW-1:0] drain_q, drain_d;

    logic                job_accept_c;
    logic                w_step, x_step;
    logic [ADDR_BW-1:0]  w_addr_c, x_addr_c;
    logic                w_all_c, x_all_c;

    assign job_accept_c = (state_q == IDLE) && start && (cfg_len != '0);

    mac_ctrl_addr_gen #(
        .ADDR_BW (ADDR_BW),
        .CNT_BW  (CNT_BW)
    ) u_w_gen (
        .clk            (clk),
        .rst_n          (reset),
        .load_i         (job_accept_c),
        .base_i         (cfg_w_base),
        .len_i          (CNT_BW'(COL)),
        .step_i         (w_step),
        .addr_c_o       (w_addr_c),
        .all_issued_c_o (w_all_c)
    );

    mac_ctrl_addr_gen #(
        .ADDR_BW (ADDR_BW),
        .CNT_BW  (CNT_BW)
    ) u_x_gen (
        .clk            (clk),
        .rst_n          (reset),
        .load_i         (job_accept_c),
        .base_i         (cfg_x_base),
        .len_i          (CNT_BW'(cfg_len)),
        .step_i         (x_step),
        .addr_c_o       (x_addr_c),
        .all_issued_c_o (x_all_c)
    );

    always_comb begin
        state_d    = state_q;
        mem_ren_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        inst_w_d   = INST_IDLE;
        done_d     = 1'b0;
        err_d      = err_q;
        len_d      = len_q;
        vcnt_d     = vcnt_q;
        drain_d    = drain_q;
        w_step     = 1'b0;
        x_step     = 1'b0;

        // Instruction trails its read by one cycle so it meets the SRAM data.
        if (mem_ren_q) begin
            inst_w_d = (state_q == LOAD) ? INST_LOAD : INST_EXEC;
        end

        if (((state_q == EXEC) || (state_q == DRAIN)) && valid[COL-1] && (vcnt_q != len_q)) begin
            vcnt_d = vcnt_q + LEN_BW'(1);
        end

        case (state_q)
            IDLE: begin
                if (job_accept_c) begin
                    err_d      = 1'b0;
                    len_d      = cfg_len;
                    vcnt_d     = '0;
                    w_step     = 1'b1;
                    mem_ren_d  = 1'b1;
                    mem_addr_d = w_addr_c;
                    state_d    = LOAD;
                end else if (start) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            LOAD: begin
                if (w_all_c) begin
                    state_d = GAP;
                end else begin
                    w_step     = 1'b1;
                    mem_ren_d  = 1'b1;
                    mem_addr_d = w_addr_c;
                end
            end
            GAP: begin
                x_step     = 1'b1;
                mem_ren_d  = 1'b1;
                mem_addr_d = x_addr_c;
                state_d    = EXEC;
            end
            EXEC: begin
                if (x_all_c) begin
                    drain_d = DRAIN_BW'(1);
                    state_d = DRAIN;
                end else begin
                    x_step     = 1'b1;
                    mem_ren_d  = 1'b1;
                    mem_addr_d = x_addr_c;
                end
            end
            DRAIN: begin
                // drain_q counts cycles since the last activation read.
                if (vcnt_d == len_q) begin
                    state_d = DONE;
                end else if (drain_q == DRAIN_BW'(DRAIN_LIMIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DRAIN_BW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DONE) begin
            done_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_ren_q  <= 1'b0;
            mem_addr_q <= '0;
            inst_w_q   <= INST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            len_q      <= '0;
            vcnt_q     <= '0;
            drain_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_ren_q  <= mem_ren_d;
            mem_addr_q <= mem_addr_d;
            inst_w_q   <= inst_w_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            len_q      <= len_d;
            vcnt_q     <= vcnt_d;
            drain_q    <= drain_d;
        end
    end

    assign mem_ren  = mem_ren_q;
    assign mem_addr = mem_addr_q;
    assign inst_w   = inst_w_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mac_ctrl.sv
// Scoreboard bench for mac_ctrl: jobs push expected reads, instructions and done results;
// a monitor compares them against the DUT outputs each cycle.
module tb_mac_ctrl;
    import mac_pkg::*;

    localparam int ROW       = 8;
    localparam int COL       = 8;
    localparam int LEN_BW    = 8;
    localparam int ADDR_BW   = 11;
    localparam int DRAIN_LAT = 20;  // ROW + COL + 4 for the default geometry

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [LEN_BW-1:0]  cfg_len;
    logic [ADDR_BW-1:0] cfg_w_base;
    logic [ADDR_BW-1:0] cfg_x_base;
    logic               mem_ren;
    logic [ADDR_BW-1:0] mem_addr;
    logic [1:0]         inst_w;
    logic [COL-1:0]     valid;
    logic               busy;
    logic               done;
    logic               err;

    mac_ctrl #(
        .ROW     (ROW),
        .COL     (COL),
        .LEN_BW  (LEN_BW),
        .ADDR_BW (ADDR_BW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_len    (cfg_len),
        .cfg_w_base (cfg_w_base),
        .cfg_x_base (cfg_x_base),
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .inst_w     (inst_w),
        .valid      (valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_BW-1:0] addr;
        int                 gap;   // idle cycles since previous read, -1 = don't care
    } rd_t;

    typedef struct {
        logic err;
        int   lat;                 // cycles from last read to done, -1 = don't care
    } done_exp_t;

    rd_t        rd_q[$];
    logic [1:0] inst_q[$];
    done_exp_t  done_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got event with value 0x%0h, expected no event", name, act);
    endtask

    // Monitor: pops expectations whenever the DUT issues a read or a done pulse.
    initial begin : monitor
        int         cyc;
        int         last_rd;
        logic [1:0] pend;
        rd_t        r;
        done_exp_t  d;
        cyc     = 0;
        last_rd = 0;
        pend    = INST_IDLE;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend = INST_IDLE;
            end else begin
                cyc++;
                check("inst_w", 32'(inst_w), 32'(pend));
                pend = INST_IDLE;
                if (mem_ren) begin
                    if (rd_q.size() == 0) begin
                        unexpected("mem_ren", 32'(mem_addr));
                    end else begin
                        r = rd_q.pop_front();
                        check("mem_addr", 32'(mem_addr), 32'(r.addr));
                        if (r.gap >= 0) check("read_gap", 32'(cyc - last_rd - 1), 32'(r.gap));
                    end
                    if (inst_q.size() != 0) pend = inst_q.pop_front();
                    last_rd = cyc;
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        unexpected("done", 32'(err));
                    end else begin
                        d = done_q.pop_front();
                        check("done_err", 32'(err), 32'(d.err));
                        if (d.lat >= 0) check("done_latency", 32'(cyc - last_rd), 32'(d.lat));
                    end
                end
            end
        end
    end

    task automatic push_job(input int len, input int wb, input int xb,
                            input logic exp_err, input int exp_lat);
        rd_t       r;
        done_exp_t d;
        if (len != 0) begin
            for (int k = 0; k < COL; k++) begin
                r.addr = ADDR_BW'(wb + k);
                r.gap  = (k == 0) ? -1 : 0;
                rd_q.push_back(r);
                inst_q.push_back(INST_LOAD);
            end
            for (int j = 0; j < len; j++) begin
                r.addr = ADDR_BW'(xb + j);
                r.gap  = (j == 0) ? 1 : 0;
                rd_q.push_back(r);
                inst_q.push_back(INST_EXEC);
            end
        end
        d.err = exp_err;
        d.lat = exp_lat;
        done_q.push_back(d);
    endtask

    // Runs one job; valid[COL-1] is driven in cycles vfirst..vfirst+vn-1 after start is taken.
    task automatic run_job(input int len, input int wb, input int xb, input int vfirst,
                           input int vn, input bit noise, input bit repulse,
                           input logic exp_err, input int exp_lat);
        bit seen;
        seen = 1'b0;
        push_job(len, wb, xb, exp_err, exp_lat);
        cfg_len    = LEN_BW'(len);
        cfg_w_base = ADDR_BW'(wb);
        cfg_x_base = ADDR_BW'(xb);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        cfg_len    = 8'hA5;
        cfg_w_base = 11'h555;
        cfg_x_base = 11'h2AA;
        for (int c = 1; c <= 200 && !seen; c++) begin
            valid = '0;
            if (noise) valid[COL-2:0] = '1;
            if (c >= vfirst && c < vfirst + vn) valid[COL-1] = 1'b1;
            start = repulse && (c == 3);
            @(negedge clk);
            if (c == 1) check("busy_after_start", 32'(busy), 32'(len != 0));
            seen = done;
            @(posedge clk); #1;
        end
        valid = '0;
        start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset      = 1'b0;
        start      = 1'b0;
        cfg_len    = '0;
        cfg_w_base = '0;
        cfg_x_base = '0;
        valid      = '0;
        #12;
        check("rst_mem_ren", 32'(mem_ren), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_inst_w", 32'(inst_w), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic job; valid[7] pulses straddle the end of EXEC.
        run_job(4, 'h010, 'h040, 12, 4, 1'b0, 1'b0, 1'b0, 3);

        // Zero-length job: error, done, no reads; error is sticky.
        run_job(0, 'h010, 'h040, 0, 0, 1'b0, 1'b0, 1'b1, -1);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", 32'(err), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Address wrap on both streams; accepted start clears the error.
        run_job(4, 'h7FC, 'h7FE, 12, 4, 1'b0, 1'b0, 1'b0, 3);
        check("err_cleared", 32'(err), 32'd0);

        // No valid[7] at all (other bits busy): drain timeout.
        run_job(4, 'h100, 'h200, 0, 0, 1'b1, 1'b0, 1'b1, DRAIN_LAT);
        check("err_after_timeout", 32'(err), 32'd1);

        // All results arrive during EXEC.
        run_job(2, 'h000, 'h7FF, 10, 2, 1'b0, 1'b0, 1'b0, 2);

        // Start re-pulsed during LOAD with different config is ignored.
        run_job(4, 'h030, 'h050, 12, 4, 1'b0, 1'b1, 1'b0, 3);

        // Reset in the middle of EXEC aborts without a done pulse.
        push_job(4, 'h020, 'h060, 1'b0, -1);
        cfg_len    = 8'd4;
        cfg_w_base = 11'h020;
        cfg_x_base = 11'h060;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_mem_ren", 32'(mem_ren), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_inst_w", 32'(inst_w), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        rd_q.delete();
        inst_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        run_job(4, 'h018, 'h048, 12, 4, 1'b0, 1'b0, 1'b0, 3);

        repeat (4) @(posedge clk);
        #1;
        check("rd_q_left", 32'(rd_q.size()), 32'd0);
        check("inst_q_left", 32'(inst_q.size()), 32'd0);
        check("done_q_left", 32'(done_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
